// File: rtl/board_ram_arbiter.sv
// board_ram_arbiter
//   Single-port 10 x 20 board store (3-bit cell kinds, index y*10+x) shared by
//   a display scanner, the game logic and a full-board clear engine. One
//   access is granted per cycle. Registered results appear one cycle after
//   the grant.
//
//   Optional feature macro: BOARD_ARB_STARVE_GUARD_EN
//     defined   : a pending game request that has lost to the display
//                 STARVE_LIMIT times in a row is granted ahead of the display.
//     undefined : the display always wins and there is no starve counter.
//
// Ports
//   clk, reset                  system clock, synchronous active-high reset
//   disp_valid, disp_x, disp_y  display lookup request and cell coordinates
//   disp_kind, disp_stall       looked-up kind (0 = empty) / not-refreshed flag
//   gm_req, gm_we               game access request and write select
//   gm_x, gm_y, gm_wdata        game cell coordinates and write data
//   gm_ack, gm_rdata            access-complete pulse and read data
//   clr_req                     start a full-board clear
//   clr_busy, clr_done          clear in progress / one-cycle completion pulse
module board_ram_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       disp_valid,
  input  logic [3:0] disp_x,
  input  logic [4:0] disp_y,
  output logic [2:0] disp_kind,
  output logic       disp_stall,
  input  logic       gm_req,
  input  logic       gm_we,
  input  logic [3:0] gm_x,
  input  logic [4:0] gm_y,
  input  logic [2:0] gm_wdata,
  output logic       gm_ack,
  output logic [2:0] gm_rdata,
  input  logic       clr_req,
  output logic       clr_busy,
  output logic       clr_done
);

  localparam int         NCELLS    = 200;
  localparam logic [7:0] LAST_CELL = 8'd199;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t     state_q, state_d;
  logic [2:0] cells_q [NCELLS];
  logic [2:0] cells_d [NCELLS];
  logic [7:0] clr_idx_q, clr_idx_d;
  logic [2:0] disp_kind_q, disp_kind_d;
  logic       disp_stall_q, disp_stall_d;
  logic       gm_ack_q, gm_ack_d;
  logic [2:0] gm_rdata_q, gm_rdata_d;
  logic       clr_done_q, clr_done_d;

  logic       disp_grant;
  logic       gm_grant;
  logic       force_gm;

  function automatic logic [7:0] cell_index(input logic [3:0] x, input logic [4:0] y);
    logic [7:0] y8;
    y8 = {3'b000, y};
    return (y8 << 3) + (y8 << 1) + {4'b0000, x};
  endfunction

  logic       disp_in_range, gm_in_range;
  logic [7:0] disp_idx, gm_idx;
  logic [2:0] disp_cell, gm_cell;

  // Out-of-board coordinates read as empty and never alias onto a real cell.
  assign disp_in_range = (disp_x < 4'd10) && (disp_y < 5'd20);
  assign gm_in_range   = (gm_x < 4'd10) && (gm_y < 5'd20);
  assign disp_idx      = cell_index(disp_x, disp_y);
  assign gm_idx        = cell_index(gm_x, gm_y);
  assign disp_cell     = disp_in_range ? cells_q[disp_idx] : 3'd0;
  assign gm_cell       = gm_in_range ? cells_q[gm_idx] : 3'd0;

`ifdef BOARD_ARB_STARVE_GUARD_EN
  localparam int STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_q, starve_d;

  assign force_gm = gm_req && (starve_q == STARVE_MAX);

  // Counts cycles a request waits (including during a clear); saturates so
  // the forced grant fires on the first IDLE cycle once the limit is reached.
  always_comb begin
    starve_d = starve_q;
    if (gm_grant) begin
      starve_d = '0;
    end else if (gm_req && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_gm = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (clr_req) state_d = S_CLEAR;
      S_CLEAR: if (clr_idx_q == LAST_CELL) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: grant selection and clear status
  always_comb begin
    disp_grant = 1'b0;
    gm_grant   = 1'b0;
    clr_busy   = (state_q == S_CLEAR);
    // A clr_req cycle is spent entering CLEAR, so nothing else is granted.
    if ((state_q == S_IDLE) && !clr_req) begin
      if (force_gm) begin
        gm_grant = 1'b1;
      end else if (disp_valid) begin
        disp_grant = 1'b1;
      end else if (gm_req) begin
        gm_grant = 1'b1;
      end
    end
  end

  // Storage access and registered results
  always_comb begin
    cells_d      = cells_q;
    clr_idx_d    = clr_idx_q;
    disp_kind_d  = disp_kind_q;
    disp_stall_d = 1'b0;
    gm_ack_d     = 1'b0;
    gm_rdata_d   = gm_rdata_q;
    clr_done_d   = 1'b0;
    if (state_q == S_CLEAR) begin
      cells_d[clr_idx_q] = 3'd0;
      disp_kind_d        = 3'd0;
      if (clr_idx_q == LAST_CELL) begin
        clr_idx_d  = 8'd0;
        clr_done_d = 1'b1;
      end else begin
        clr_idx_d = clr_idx_q + 8'd1;
      end
    end else if (clr_req) begin
      // Blank the display output from the first clear cycle onward.
      disp_kind_d = 3'd0;
    end else begin
      if (disp_grant) begin
        disp_kind_d = disp_cell;
      end else begin
        disp_stall_d = disp_valid;
      end
      if (gm_grant) begin
        gm_ack_d = 1'b1;
        if (gm_we) begin
          if (gm_in_range) cells_d[gm_idx] = gm_wdata;
        end else begin
          gm_rdata_d = gm_cell;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cells_q      <= '{default: 3'd0};
      clr_idx_q    <= 8'd0;
      disp_kind_q  <= 3'd0;
      disp_stall_q <= 1'b0;
      gm_ack_q     <= 1'b0;
      gm_rdata_q   <= 3'd0;
      clr_done_q   <= 1'b0;
    end else begin
      cells_q      <= cells_d;
      clr_idx_q    <= clr_idx_d;
      disp_kind_q  <= disp_kind_d;
      disp_stall_q <= disp_stall_d;
      gm_ack_q     <= gm_ack_d;
      gm_rdata_q   <= gm_rdata_d;
      clr_done_q   <= clr_done_d;
    end
  end

  assign disp_kind  = disp_kind_q;
  assign disp_stall = disp_stall_q;
  assign gm_ack     = gm_ack_q;
  assign gm_rdata   = gm_rdata_q;
  assign clr_done   = clr_done_q;

endmodule

// File: tb/tb_board_ram_arbiter.sv
// Testbench for board_ram_arbiter: directed vector table, multi-cycle clear /
// reset / arbitration sequences, and a randomized run against a cell-array
// reference model.
module tb_board_ram_arbiter;

  localparam int STARVE_LIMIT = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       disp_valid;
  logic [3:0] disp_x;
  logic [4:0] disp_y;
  logic [2:0] disp_kind;
  logic       disp_stall;
  logic       gm_req;
  logic       gm_we;
  logic [3:0] gm_x;
  logic [4:0] gm_y;
  logic [2:0] gm_wdata;
  logic       gm_ack;
  logic [2:0] gm_rdata;
  logic       clr_req;
  logic       clr_busy;
  logic       clr_done;

  board_ram_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .disp_valid(disp_valid), .disp_x(disp_x), .disp_y(disp_y),
    .disp_kind(disp_kind), .disp_stall(disp_stall),
    .gm_req(gm_req), .gm_we(gm_we), .gm_x(gm_x), .gm_y(gm_y), .gm_wdata(gm_wdata),
    .gm_ack(gm_ack), .gm_rdata(gm_rdata),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: the board as a plain array plus clear progress.
  logic [2:0] mem [200];
  bit         clearing;
  int         ccount;
  int         starve;
  logic [2:0] exp_kind, exp_rdata;
  logic       exp_stall, exp_ack, exp_busy, exp_done;

  typedef struct {
    logic       dv;
    logic [3:0] dx;
    logic [4:0] dy;
    logic       gr;
    logic       gw;
    logic [3:0] gx;
    logic [4:0] gy;
    logic [2:0] gd;
    logic [2:0] e_kind;
    logic       e_stall;
    logic       e_ack;
    logic [2:0] e_rdata;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] cell_of(input logic [3:0] x, input logic [4:0] y);
    if (x < 4'd10 && y < 5'd20) return mem[int'(y) * 10 + int'(x)];
    return 3'd0;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit gm_grant, d_grant, forced;
    gm_grant = 1'b0;
    d_grant  = 1'b0;
    forced   = 1'b0;
    exp_ack  = 1'b0;
    exp_done = 1'b0;
    if (reset) begin
      foreach (mem[i]) mem[i] = 3'd0;
      exp_kind  = 3'd0;
      exp_stall = 1'b0;
      exp_rdata = 3'd0;
      exp_busy  = 1'b0;
      clearing  = 1'b0;
      ccount    = 0;
      starve    = 0;
      return;
    end
    if (clearing) begin
      mem[ccount] = 3'd0;
      ccount++;
      exp_kind  = 3'd0;
      exp_stall = 1'b0;
      if (ccount == 200) begin
        clearing = 1'b0;
        ccount   = 0;
        exp_done = 1'b1;
      end
    end else if (clr_req) begin
      clearing  = 1'b1;
      exp_kind  = 3'd0;
      exp_stall = 1'b0;
    end else begin
`ifdef BOARD_ARB_STARVE_GUARD_EN
      forced = gm_req && (starve == STARVE_LIMIT);
`endif
      if (forced) gm_grant = 1'b1;
      else if (disp_valid) d_grant = 1'b1;
      else if (gm_req) gm_grant = 1'b1;
      if (d_grant) begin
        exp_kind  = cell_of(disp_x, disp_y);
        exp_stall = 1'b0;
      end else begin
        exp_stall = disp_valid;
      end
      if (gm_grant) begin
        exp_ack = 1'b1;
        if (gm_we) begin
          if (gm_x < 4'd10 && gm_y < 5'd20) mem[int'(gm_y) * 10 + int'(gm_x)] = gm_wdata;
        end else begin
          exp_rdata = cell_of(gm_x, gm_y);
        end
      end
    end
    if (gm_grant) starve = 0;
    else if (gm_req && starve < STARVE_LIMIT) starve++;
    exp_busy = clearing;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_model();
    check("disp_kind", 32'(disp_kind), 32'(exp_kind));
    check("disp_stall", 32'(disp_stall), 32'(exp_stall));
    check("gm_ack", 32'(gm_ack), 32'(exp_ack));
    check("gm_rdata", 32'(gm_rdata), 32'(exp_rdata));
    check("clr_busy", 32'(clr_busy), 32'(exp_busy));
    check("clr_done", 32'(clr_done), 32'(exp_done));
  endtask

  task automatic set_idle();
    disp_valid = 1'b0; disp_x = 4'd0; disp_y = 5'd0;
    gm_req = 1'b0; gm_we = 1'b0; gm_x = 4'd0; gm_y = 5'd0; gm_wdata = 3'd0;
    clr_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_cnt, done_cnt, edge_ok, nz, done_at, ack_at, ack_busy;
    logic prev_busy;
    bit pend;
`ifdef BOARD_ARB_STARVE_GUARD_EN
    logic [2:0] prev_kind;
`endif

    // ---- reset state ----
    reset = 1'b1;
    set_idle();
    @(negedge clk);
    tick();
    tick();
    check("rst_disp_kind", 32'(disp_kind), 0);
    check("rst_disp_stall", 32'(disp_stall), 0);
    check("rst_gm_ack", 32'(gm_ack), 0);
    check("rst_gm_rdata", 32'(gm_rdata), 0);
    check("rst_clr_busy", 32'(clr_busy), 0);
    check("rst_clr_done", 32'(clr_done), 0);
    reset = 1'b0;

    // ---- directed vector table (one cycle per row, results after the edge) ----
    //               dv    dx     dy     gr    gw    gx     gy     gd     kind  stall ack   rdata
    vecs[0]  = '{1'b0, 4'd0,  5'd0,  1'b1, 1'b1, 4'd3,  5'd5,  3'd6,  3'd0, 1'b0, 1'b1, 3'd0};
    vecs[1]  = '{1'b1, 4'd3,  5'd5,  1'b0, 1'b0, 4'd0,  5'd0,  3'd0,  3'd6, 1'b0, 1'b0, 3'd0};
    vecs[2]  = '{1'b1, 4'd3,  5'd5,  1'b1, 1'b0, 4'd3,  5'd5,  3'd0,  3'd6, 1'b0, 1'b0, 3'd0};
    vecs[3]  = '{1'b0, 4'd0,  5'd0,  1'b1, 1'b0, 4'd3,  5'd5,  3'd0,  3'd6, 1'b0, 1'b1, 3'd6};
    vecs[4]  = '{1'b0, 4'd0,  5'd0,  1'b1, 1'b0, 4'd12, 5'd5,  3'd0,  3'd6, 1'b0, 1'b1, 3'd0};
    vecs[5]  = '{1'b0, 4'd0,  5'd0,  1'b1, 1'b1, 4'd12, 5'd5,  3'd5,  3'd6, 1'b0, 1'b1, 3'd0};
    vecs[6]  = '{1'b1, 4'd2,  5'd6,  1'b0, 1'b0, 4'd0,  5'd0,  3'd0,  3'd0, 1'b0, 1'b0, 3'd0};
    vecs[7]  = '{1'b0, 4'd0,  5'd0,  1'b1, 1'b1, 4'd9,  5'd19, 3'd7,  3'd0, 1'b0, 1'b1, 3'd0};
    vecs[8]  = '{1'b1, 4'd9,  5'd19, 1'b0, 1'b0, 4'd0,  5'd0,  3'd0,  3'd7, 1'b0, 1'b0, 3'd0};
    vecs[9]  = '{1'b0, 4'd0,  5'd0,  1'b1, 1'b0, 4'd9,  5'd19, 3'd0,  3'd7, 1'b0, 1'b1, 3'd7};
    vecs[10] = '{1'b1, 4'd2,  5'd20, 1'b0, 1'b0, 4'd0,  5'd0,  3'd0,  3'd0, 1'b0, 1'b0, 3'd7};
    vecs[11] = '{1'b0, 4'd0,  5'd0,  1'b0, 1'b0, 4'd0,  5'd0,  3'd0,  3'd0, 1'b0, 1'b0, 3'd7};
    vecs[12] = '{1'b0, 4'd0,  5'd0,  1'b1, 1'b0, 4'd3,  5'd5,  3'd0,  3'd0, 1'b0, 1'b1, 3'd6};
    vecs[13] = '{1'b1, 4'd15, 5'd31, 1'b0, 1'b0, 4'd0,  5'd0,  3'd0,  3'd0, 1'b0, 1'b0, 3'd6};

    foreach (vecs[i]) begin
      disp_valid = vecs[i].dv; disp_x = vecs[i].dx; disp_y = vecs[i].dy;
      gm_req = vecs[i].gr; gm_we = vecs[i].gw; gm_x = vecs[i].gx; gm_y = vecs[i].gy;
      gm_wdata = vecs[i].gd; clr_req = 1'b0;
      tick();
      check($sformatf("vec%0d_kind", i), 32'(disp_kind), 32'(vecs[i].e_kind));
      check($sformatf("vec%0d_stall", i), 32'(disp_stall), 32'(vecs[i].e_stall));
      check($sformatf("vec%0d_ack", i), 32'(gm_ack), 32'(vecs[i].e_ack));
      check($sformatf("vec%0d_rdata", i), 32'(gm_rdata), 32'(vecs[i].e_rdata));
      check($sformatf("vec%0d_busy", i), 32'(clr_busy), 0);
    end
    set_idle();
    tick();
    check_model();

    // ---- fill the board, clear it, sweep it ----
    for (int i = 0; i < 200; i++) begin
      set_idle();
      gm_req = 1'b1; gm_we = 1'b1;
      gm_x = 4'(i % 10); gm_y = 5'(i / 10); gm_wdata = 3'((i % 7) + 1);
      tick();
      check_model();
      set_idle();
      tick();
      check_model();
    end
    set_idle();
    clr_req = 1'b1;
    tick();
    check_model();
    clr_req = 1'b0;
    busy_cnt = clr_busy ? 1 : 0;
    done_cnt = 0;
    edge_ok  = 0;
    for (int c = 0; c < 260; c++) begin
      disp_valid = 1'b1;
      disp_x = 4'($urandom_range(0, 9));
      disp_y = 5'($urandom_range(0, 19));
      prev_busy = clr_busy;
      tick();
      check_model();
      if (clr_busy) busy_cnt++;
      if (clr_done) begin
        done_cnt++;
        if (prev_busy && !clr_busy) edge_ok++;
      end
    end
    check("clr_busy_cycles", busy_cnt, 200);
    check("clr_done_pulses", done_cnt, 1);
    check("clr_done_at_busy_fall", edge_ok, 1);
    nz = 0;
    for (int i = 0; i < 200; i++) begin
      set_idle();
      disp_valid = 1'b1; disp_x = 4'(i % 10); disp_y = 5'(i / 10);
      tick();
      check_model();
      if (disp_kind != 3'd0 || disp_stall) nz++;
    end
    check("sweep_after_clear_nonzero", nz, 0);

    // ---- reset in the middle of a clear ----
    for (int i = 150; i < 160; i++) begin
      set_idle();
      gm_req = 1'b1; gm_we = 1'b1;
      gm_x = 4'(i % 10); gm_y = 5'(i / 10); gm_wdata = 3'd5;
      tick();
      check_model();
      set_idle();
      tick();
    end
    set_idle();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 0; c < 50; c++) tick();
    check("clear_running_before_reset", 32'(clr_busy), 1);
    reset = 1'b1;
    tick();
    check_model();
    reset = 1'b0;
    check("busy_after_abort", 32'(clr_busy), 0);
    done_cnt = 0;
    for (int c = 0; c < 220; c++) begin
      tick();
      check_model();
      if (clr_done) done_cnt++;
    end
    check("no_done_after_abort", done_cnt, 0);
    nz = 0;
    for (int i = 150; i < 160; i++) begin
      disp_valid = 1'b1; disp_x = 4'(i % 10); disp_y = 5'(i / 10);
      tick();
      check_model();
      if (disp_kind != 3'd0) nz++;
    end
    check("cells_zero_after_abort", nz, 0);

    // ---- clear and game write requested together ----
    set_idle();
    clr_req = 1'b1;
    gm_req = 1'b1; gm_we = 1'b1; gm_x = 4'd4; gm_y = 5'd7; gm_wdata = 3'd3;
    tick();
    check_model();
    clr_req = 1'b0;
    done_at  = -1;
    ack_at   = -1;
    ack_busy = 0;
    for (int c = 0; c < 260 && ack_at < 0; c++) begin
      tick();
      check_model();
      if (clr_done) done_at = c;
      if (gm_ack) begin
        ack_at = c;
        if (clr_busy) ack_busy++;
      end
    end
    check("game_ack_seen", 32'(ack_at >= 0), 1);
    check("game_ack_after_done", ack_at - done_at, 1);
    check("game_ack_during_clear", ack_busy, 0);
    set_idle();
    disp_valid = 1'b1; disp_x = 4'd4; disp_y = 5'd7;
    tick();
    check_model();
    check("write_persists_after_clear", 32'(disp_kind), 3);

`ifdef BOARD_ARB_STARVE_GUARD_EN
    // ---- starve guard: display held busy, game read waiting ----
    set_idle();
    tick();
    check_model();
    gm_req = 1'b1; gm_we = 1'b0; gm_x = 4'd4; gm_y = 5'd7;
    disp_valid = 1'b1;
    ack_at = -1;
    for (int c = 1; c <= 20 && ack_at < 0; c++) begin
      disp_x = (c % 2 == 1) ? 4'd4 : 4'd5;
      disp_y = 5'd7;
      prev_kind = disp_kind;
      tick();
      check_model();
      if (gm_ack) begin
        ack_at = c;
        check("guard_stall", 32'(disp_stall), 1);
        check("guard_kind_hold", 32'(disp_kind), 32'(prev_kind));
        check("guard_rdata", 32'(gm_rdata), 3);
      end
    end
    check("guard_grant_cycle", ack_at, STARVE_LIMIT + 1);
    set_idle();
    tick();
    check_model();
`endif

    // ---- randomized run against the model ----
    pend = 1'b0;
    set_idle();
    for (int n = 0; n < 4000; n++) begin
      reset      = ($urandom_range(0, 699) == 0);
      clr_req    = ($urandom_range(0, 599) == 0);
      disp_valid = 1'($urandom_range(0, 1));
      disp_x     = 4'($urandom_range(0, 11));
      disp_y     = 5'($urandom_range(0, 21));
      if (exp_ack) pend = 1'b0;
      if (reset) begin
        pend = 1'b0;
      end else if (!pend && $urandom_range(0, 9) < 4) begin
        pend     = 1'b1;
        gm_we    = 1'($urandom_range(0, 1));
        gm_x     = 4'($urandom_range(0, 11));
        gm_y     = 5'($urandom_range(0, 21));
        gm_wdata = 3'($urandom_range(0, 7));
      end
      gm_req = pend;
      tick();
      check_model();
    end
    reset = 1'b0;
    set_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/board_ram_arbiter.md
BOARD_RAM_ARBITER -- requirements
Module: board_ram_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 8, max consecutive cycles a pending game request may lose to the display.
REQ-002 Port: clk  input  1  system clock, all logic on posedge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: disp_valid  input  1  display lookup request this cycle.
REQ-005 Port: disp_x / disp_y  input  4 / 5  display cell column / row.
REQ-006 Port: disp_kind  output  3  cell kind returned to the display, 0 = empty.
REQ-007 Port: disp_stall  output  1  disp_kind was not refreshed this cycle.
REQ-008 Port: gm_req / gm_we  input  1 / 1  game access request / write select.
REQ-009 Port: gm_x / gm_y / gm_wdata  input  4 / 5 / 3  game cell address and write data.
REQ-010 Port: gm_ack / gm_rdata  output  1 / 3  access-complete pulse / read data.
REQ-011 Port: clr_req  input  1  start full-board clear; clr_busy  output  1; clr_done  output  1  one-cycle pulse.

Function
REQ-012 Storage is a 10 x 20 array of 3-bit cells (index y*10+x) with one access per cycle.
REQ-013 FSM has two states, IDLE and CLEAR; IDLE -> CLEAR on clr_req, CLEAR -> IDLE after cell 199 is written.
REQ-014 IDLE grant order: forced game (starve guard) > display (disp_valid) > game (gm_req).
REQ-015 Display grant: disp_kind = cell(disp_x, disp_y) registered one cycle after the request; disp_stall = 0.
REQ-016 No display grant in a cycle: disp_kind holds its value; disp_stall = 1 only if disp_valid was high.
REQ-017 Game grant: gm_ack pulses one cycle after the grant; on a read, gm_rdata is valid with gm_ack; on a write, the cell updates at the grant edge.
REQ-018 gm_req and its fields stay stable until gm_ack; gm_req sampled in the gm_ack cycle is a new request.
REQ-019 Coordinates with x >= 10 or y >= 20: reads return 0, writes are dropped, game access still acks.
REQ-020 Read and write to the same cell cannot coincide (single port); a display read after a game write returns the new value.
REQ-021 Starve counter increments each cycle gm_req is pending and not granted, and clears on game grant.
REQ-022 CLEAR: one cell per cycle from 0 to 199, writing 0; 200 cycles total.
REQ-023 During CLEAR: clr_busy = 1, disp_kind = 0, disp_stall = 0, game requests held without ack.
REQ-024 clr_done pulses in the cycle after cell 199 is written, coincident with clr_busy falling.
REQ-025 clr_req in CLEAR is ignored; clr_req and gm_req in the same IDLE cycle: clear wins, game waits.

Reset
REQ-026 Reset clears: state = IDLE, all cells = 0, disp_kind = 0, disp_stall = 0, gm_ack = 0, gm_rdata = 0, clr_busy = 0, clr_done = 0, starve counter = 0, clear index = 0.
REQ-027 Reset mid-CLEAR or mid-handshake aborts the operation; no gm_ack or clr_done is issued for it.

Configuration
REQ-028 With macro BOARD_ARB_STARVE_GUARD_EN defined, REQ-021 applies: when the counter equals STARVE_LIMIT, the next IDLE cycle is a forced game grant.
REQ-029 Without BOARD_ARB_STARVE_GUARD_EN, the display always wins, game access occurs only when disp_valid = 0, and there is no starve counter.

Verification
REQ-030 Write (3,5)=6, then display read (3,5) -> gm_ack after 1 cycle; disp_kind = 6 one cycle after disp_valid, disp_stall = 0.
REQ-031 Read (12,5) -> gm_ack with gm_rdata = 0; a write to (12,5) leaves all cells unchanged.
REQ-032 With guard enabled, disp_valid held high and gm_req pending -> grant on the 9th cycle; that cycle disp_stall = 1 and disp_kind holds.
REQ-033 Fill board, assert clr_req -> clr_busy high for 200 cycles, clr_done pulses once, then a sweep of all 200 cells returns 0.
REQ-034 Reset at clear cycle 50 -> no clr_done, state IDLE, all cells 0.
REQ-035 clr_req and gm_req write in the same cycle -> clear runs first; the game write acks after clr_done and persists.
